id_ex_stage: RTL

//  Decode stage plus ID/EX pipeline register; consumes InstrD/PCPlus4D from the IF/ID register.

---
 rtl/id_ex_stage.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS-style decode stage with register file, early beq
// resolution, and the ID/EX pipeline register feeding the EX stage.
module id_ex_stage #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        InstrD,
  input  logic [31:0]        PCPlus4D,
  input  logic               RegWriteW,
  input  logic [RADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0]  ResultW,
  input  logic [DATA_W-1:0]  ALUOutM,
  input  logic               ForwardAD,
  input  logic               ForwardBD,
  input  logic               FlushE,
  output logic               PCSrcD,
  output logic [31:0]        PCBranchD,
  output logic               BranchD,
  output logic [RADDR_W-1:0] RsD,
  output logic [RADDR_W-1:0] RtD,
  output logic               RegWriteE,
  output logic               MemtoRegE,
  output logic               MemWriteE,
  output logic               ALUSrcE,
  output logic               RegDstE,
  output logic [2:0]         ALUControlE,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [RADDR_W-1:0] RsE,
  output logic [RADDR_W-1:0] RtE,
  output logic [RADDR_W-1:0] RdE,
  output logic [DATA_W-1:0]  SignImmE
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Instruction fields
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [RADDR_W-1:0] rd_field;
  logic [4:0]         unused_shamt;

  assign opcode       = InstrD[31:26];
  assign funct        = InstrD[5:0];
  assign RsD          = InstrD[25:21];
  assign RtD          = InstrD[20:16];
  assign rd_field     = InstrD[15:11];
  assign unused_shamt = InstrD[10:6];

  // Decoded controls
  logic       reg_write_d;
  logic       memto_reg_d;
  logic       mem_write_d;
  logic       alu_src_d;
  logic       reg_dst_d;
  logic       branch_d;
  logic [2:0] alu_control_d;

  // Main + ALU decode; anything unrecognised decodes to an all-zero NOP,
  // which also covers InstrD = 0 arriving from an IF/ID flush.
  always_comb begin
    reg_write_d   = 1'b0;
    memto_reg_d   = 1'b0;
    mem_write_d   = 1'b0;
    alu_src_d     = 1'b0;
    reg_dst_d     = 1'b0;
    branch_d      = 1'b0;
    alu_control_d = 3'b000;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_control_d = ALU_ADD; end
          FN_SUB: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_control_d = ALU_SUB; end
          FN_AND: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_control_d = ALU_AND; end
          FN_OR:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_control_d = ALU_OR;  end
          FN_SLT: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_control_d = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LW: begin
        reg_write_d   = 1'b1;
        alu_src_d     = 1'b1;
        memto_reg_d   = 1'b1;
        alu_control_d = ALU_ADD;
      end
      OP_SW: begin
        mem_write_d   = 1'b1;
        alu_src_d     = 1'b1;
        alu_control_d = ALU_ADD;
      end
      OP_BEQ: begin
        branch_d      = 1'b1;
        alu_control_d = ALU_SUB;
      end
      OP_ADDI: begin
        reg_write_d   = 1'b1;
        alu_src_d     = 1'b1;
        alu_control_d = ALU_ADD;
      end
      default: ;
    endcase
  end

  assign BranchD = branch_d;

  // Register file storage
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register file write port; $0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWriteW && (WriteRegW != '0)) begin
      regs[WriteRegW] <= ResultW;
    end
  end

  // Read ports with write-through bypass so a value written back this
  // cycle is visible to the instruction decoding in the same cycle.
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_d;

  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (RsD != '0) begin
      if (RegWriteW && (WriteRegW == RsD)) rd1_d = ResultW;
      else                                 rd1_d = regs[RsD];
    end
    if (RtD != '0) begin
      if (RegWriteW && (WriteRegW == RtD)) rd2_d = ResultW;
      else                                 rd2_d = regs[RtD];
    end
  end

  // Immediate and branch target
  logic [DATA_W-1:0] sign_imm_d;
  logic [31:0]       imm32;

  assign sign_imm_d = {{(DATA_W-16){InstrD[15]}}, InstrD[15:0]};
  assign imm32      = {{16{InstrD[15]}}, InstrD[15:0]};
  assign PCBranchD  = PCPlus4D + {imm32[29:0], 2'b00};

  // Early beq compare with MEM-stage forwarding on either operand
  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;

  assign cmp_a  = ForwardAD ? ALUOutM : rd1_d;
  assign cmp_b  = ForwardBD ? ALUOutM : rd2_d;
  assign PCSrcD = branch_d & (cmp_a == cmp_b);

  // ID/EX register: reset beats flush beats load; a flush inserts a
  // bubble with no register or memory write side effects.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      ALUControlE <= 3'b000;
      RD1E        <= '0;
      RD2E        <= '0;
      RsE         <= '0;
      RtE         <= '0;
      RdE         <= '0;
      SignImmE    <= '0;
    end else begin
      RegWriteE   <= reg_write_d;
      MemtoRegE   <= memto_reg_d;
      MemWriteE   <= mem_write_d;
      ALUSrcE     <= alu_src_d;
      RegDstE     <= reg_dst_d;
      ALUControlE <= alu_control_d;
      RD1E        <= rd1_d;
      RD2E        <= rd2_d;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= rd_field;
      SignImmE    <= sign_imm_d;
    end
  end

endmodule
